pixel_uart_tx: RTL

PIXEL_UART_TX -- requirements
Module: pixel_uart_tx

---
 rtl/pixel_uart_tx.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/pixel_uart_tx.sv
// pixel_uart_tx: serialises one 12-bit pixel as three 8N1/8N2 UART bytes.
// Each channel nibble is sent as the high nibble of its byte, channel 0 first.
module pixel_uart_tx #(
  parameter int UART_CLKRATE_KHZ = 50000,
  parameter int UART_BAUDRATE_HZ = 115200,
  parameter int UART_STOP_BITS   = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        pix_valid,
  output logic        pix_ready,
  input  logic [11:0] pix_rgb,
  output logic        uart_tx,
  output logic        busy
);

  // Clock cycles per line bit.
  localparam int DIV   = (UART_CLKRATE_KHZ * 1000) / UART_BAUDRATE_HZ;
  localparam int CNT_W = (DIV > 2) ? $clog2(DIV) : 1;

  generate
    if (DIV < 2) begin : g_div_chk
      $error("pixel_uart_tx: bit period below 2 clock cycles");
    end
    if ((UART_STOP_BITS != 1) && (UART_STOP_BITS != 2)) begin : g_stop_chk
      $error("pixel_uart_tx: UART_STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   baud_q, baud_d;
  logic [2:0]         bit_q, bit_d;
  logic [1:0]         byte_q, byte_d;
  logic               tx_q, tx_d;
  logic               rdy_en_q;
  logic [11:0]        pix_q;
  logic               accept;
  logic               baud_last;

  // Line level for a data bit: low nibble of every byte is zero, high nibble
  // carries the channel selected by the byte index.
  function automatic logic data_bit(input logic [11:0] px,
                                    input logic [1:0]  byte_i,
                                    input logic [2:0]  bit_i);
    logic [3:0] nib;
    case (byte_i)
      2'd0:    nib = px[3:0];
      2'd1:    nib = px[7:4];
      default: nib = px[11:8];
    endcase
    return bit_i[2] ? nib[bit_i[1:0]] : 1'b0;
  endfunction

  assign accept    = pix_valid & pix_ready;
  assign baud_last = (baud_q == CNT_W'(DIV - 1));
  assign pix_ready = rdy_en_q & (state_q == IDLE);
  assign busy      = (state_q != IDLE);
  assign uart_tx   = tx_q;

  // Ready is held off during reset and enabled from the first edge after release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdy_en_q <= 1'b0;
    end else begin
      rdy_en_q <= 1'b1;
    end
  end

  // Pixel capture on handshake; contents are don't-care until first acceptance.
  always_ff @(posedge clk) begin
    if (accept) begin
      pix_q <= pix_rgb;
    end
  end

  // FSM, counters and registered line output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      tx_q    <= tx_d;
    end
  end

  // Next state, counter updates and the line level for the next cycle.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    tx_d    = tx_q;
    case (state_q)
      IDLE: begin
        tx_d   = 1'b1;
        baud_d = '0;
        bit_d  = '0;
        byte_d = '0;
        if (accept) begin
          state_d = START;
          tx_d    = 1'b0;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (baud_last) begin
          baud_d  = '0;
          state_d = DATA;
          tx_d    = data_bit(pix_q, byte_q, 3'd0);
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      DATA: begin
        tx_d = data_bit(pix_q, byte_q, bit_q);
        if (baud_last) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            bit_d   = '0;
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_d = bit_q + 3'd1;
            tx_d  = data_bit(pix_q, byte_q, bit_q + 3'd1);
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (baud_last) begin
          baud_d = '0;
          // The bit index doubles as the stop-bit counter.
          if (bit_q == 3'(UART_STOP_BITS - 1)) begin
            bit_d = '0;
            if (byte_q == 2'd2) begin
              byte_d  = '0;
              state_d = IDLE;
            end else begin
              byte_d  = byte_q + 2'd1;
              state_d = START;
              tx_d    = 1'b0;
            end
          end else begin
            bit_d = bit_q + 3'd1;
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

endmodule
